// File: rtl/pe_issue_seq_pkg.sv
// Shared definitions for the pe_core_v2 issue sequencer.
//  - instruction field layout: {opcode[31:25], func[24:20], regs[19:0]}
//  - opcode encodings for the PE functional units
//  - sequencer FSM state encoding
//  - make_instr(): assembles an instruction word from its fields
package pe_issue_seq_pkg;

  localparam int INSTR_W  = 32;
  localparam int TAG_W    = 4;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 25;
  localparam int FUNC_MSB = 24;
  localparam int FUNC_LSB = 20;
  localparam int REGS_MSB = 19;
  localparam int REGS_LSB = 0;

  localparam logic [6:0] OPC_ARITH = 7'h01;
  localparam logic [6:0] OPC_FPU   = 7'h02;
  localparam logic [6:0] OPC_COMP  = 7'h03;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic logic [INSTR_W-1:0] make_instr(input logic [6:0]  opc,
                                                    input logic [4:0]  func,
                                                    input logic [19:0] regs);
    return {opc, func, regs};
  endfunction

endpackage

// File: rtl/pe_issue_seq_if.sv
// Issue channel between the sequencer (master) and a pe_core_v2 (slave).
//  valid/instr/op1..op3 : issue request, driven by the master
//  ready                : PE can accept an issue
//  result/result_valid  : PE result, one-cycle pulse per accepted op
// Handshake: a transfer happens in a cycle where valid and ready are both
// high. Once valid is raised the master holds valid and all payload stable
// until that cycle; ready may change freely and does not depend on valid.
interface pe_issue_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [31:0]           instr;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [DATA_WIDTH-1:0] op3;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid;

  modport master (
    output valid, instr, op1, op2, op3,
    input  ready, result, result_valid
  );

  modport slave (
    input  valid, instr, op1, op2, op3,
    output ready, result, result_valid
  );
endinterface

// File: rtl/pe_issue_seq_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read port.
//  clk, rst   : clock, synchronous active-high reset (flushes pointers/count)
//  push_i     : write wdata_i (ignored when full)
//  pop_i      : drop head entry (ignored when empty)
//  rdata_o    : head entry, valid whenever empty_o is low
//  full_o, empty_o, count_o : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module pe_issue_seq_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: stale words are never visible while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pe_issue_seq.sv
// Issue sequencer for one pe_core_v2.
// Buffers host commands, issues them one at a time over the pe interface,
// and collects results (or timeout markers) into an in-order tagged FIFO.
//  clk, rst                 : clock, synchronous active-high reset
//  cmd_valid_i/cmd_ready_o  : host command handshake
//  cmd_instr_i, cmd_op*_i   : command payload
//  pe                       : issue channel to the PE (master side)
//  res_valid_o/res_ready_i  : host result handshake
//  res_data_o/tag_o/timeout_o : head result entry (0 when empty)
//  busy_o                   : op in progress or commands pending
//  issued/retired/timeout_cnt_o : status counters
//  state_dbg_o              : current FSM state
module pe_issue_seq
  import pe_issue_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int RES_DEPTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [INSTR_W-1:0]    cmd_instr_i,
  input  logic [DATA_WIDTH-1:0] cmd_op1_i,
  input  logic [DATA_WIDTH-1:0] cmd_op2_i,
  input  logic [DATA_WIDTH-1:0] cmd_op3_i,
  pe_issue_seq_if.master        pe,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic [TAG_W-1:0]      res_tag_o,
  output logic                  res_timeout_o,
  output logic                  busy_o,
  output logic [15:0]           issued_cnt_o,
  output logic [15:0]           retired_cnt_o,
  output logic [7:0]            timeout_cnt_o,
  output state_t                state_dbg_o
);

  localparam int CMD_W = INSTR_W + 3 * DATA_WIDTH;
  localparam int RES_W = 1 + TAG_W + DATA_WIDTH;
  localparam int CCW   = $clog2(CMD_DEPTH) + 1;
  localparam int RCW   = $clog2(RES_DEPTH) + 1;
  localparam int WCW   = $clog2(TIMEOUT + 1);

  // Command FIFO
  logic                  cmd_full, cmd_empty, cmd_pop;
  logic [CCW-1:0]        cmd_count;
  logic [CMD_W-1:0]      cmd_rdata;
  logic [INSTR_W-1:0]    head_instr;
  logic [DATA_WIDTH-1:0] head_op1, head_op2, head_op3;

  // Result FIFO
  logic                  res_full, res_empty, res_push, res_pop;
  logic [RCW-1:0]        res_count;
  logic [RES_W-1:0]      res_wdata, res_rdata;
  logic                  head_to;
  logic [TAG_W-1:0]      head_tag;
  logic [DATA_WIDTH-1:0] head_data;

  // Sequencer state
  state_t                state_q, state_d;
  logic                  pe_valid_q, pe_valid_d;
  logic [INSTR_W-1:0]    instr_q, instr_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
  logic [WCW-1:0]        wait_q, wait_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [15:0]           issued_q, issued_d;
  logic [15:0]           retired_q, retired_d;
  logic [7:0]            tmo_q, tmo_d;

  assign cmd_ready_o = !cmd_full;

  pe_issue_seq_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid_i && cmd_ready_o),
    .wdata_i ({cmd_instr_i, cmd_op1_i, cmd_op2_i, cmd_op3_i}),
    .pop_i   (cmd_pop),
    .rdata_o (cmd_rdata),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .count_o (cmd_count)
  );

  assign {head_instr, head_op1, head_op2, head_op3} = cmd_rdata;

  // The slot reservation in IDLE makes a full result FIFO impossible at push
  // time; the extra guard keeps a stored entry from ever being overwritten.
  pe_issue_seq_sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (res_push && !res_full),
    .wdata_i (res_wdata),
    .pop_i   (res_pop),
    .rdata_o (res_rdata),
    .full_o  (res_full),
    .empty_o (res_empty),
    .count_o (res_count)
  );

  assign {head_to, head_tag, head_data} = res_rdata;
  assign res_valid_o   = !res_empty;
  assign res_pop       = res_valid_o && res_ready_i;
  assign res_data_o    = res_empty ? '0 : head_data;
  assign res_tag_o     = res_empty ? '0 : head_tag;
  assign res_timeout_o = res_empty ? 1'b0 : head_to;

  assign pe.valid = pe_valid_q;
  assign pe.instr = instr_q;
  assign pe.op1   = op1_q;
  assign pe.op2   = op2_q;
  assign pe.op3   = op3_q;

  assign busy_o        = (state_q != ST_IDLE) || (cmd_count != '0);
  assign issued_cnt_o  = issued_q;
  assign retired_cnt_o = retired_q;
  assign timeout_cnt_o = tmo_q;
  assign state_dbg_o   = state_q;

  always_comb begin
    state_d    = state_q;
    pe_valid_d = pe_valid_q;
    instr_d    = instr_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    op3_d      = op3_q;
    wait_d     = wait_q;
    tag_d      = tag_q;
    issued_d   = issued_q;
    retired_d  = retired_q;
    tmo_d      = tmo_q;
    cmd_pop    = 1'b0;
    res_push   = 1'b0;
    res_wdata  = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Only start an op when its result is guaranteed a FIFO slot.
        if (!cmd_empty && (res_count < RCW'(RES_DEPTH))) begin
          cmd_pop    = 1'b1;
          instr_d    = head_instr;
          op1_d      = head_op1;
          op2_d      = head_op2;
          op3_d      = head_op3;
          pe_valid_d = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (pe.ready) begin
          pe_valid_d = 1'b0;
          issued_d   = issued_q + 16'd1;
          wait_d     = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A result arriving in the last allowed cycle still wins over timeout.
        if (pe.result_valid) begin
          res_push  = 1'b1;
          res_wdata = {1'b0, tag_q, pe.result};
          tag_d     = tag_q + 1'b1;
          retired_d = retired_q + 16'd1;
          state_d   = ST_IDLE;
        end else if (wait_q == WCW'(TIMEOUT - 1)) begin
          res_push  = 1'b1;
          res_wdata = {1'b1, tag_q, {DATA_WIDTH{1'b0}}};
          tag_d     = tag_q + 1'b1;
          retired_d = retired_q + 16'd1;
          tmo_d     = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
          state_d   = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pe_valid_q <= 1'b0;
      instr_q    <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      op3_q      <= '0;
      wait_q     <= '0;
      tag_q      <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      pe_valid_q <= pe_valid_d;
      instr_q    <= instr_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      op3_q      <= op3_d;
      wait_q     <= wait_d;
      tag_q      <= tag_d;
      issued_q   <= issued_d;
      retired_q  <= retired_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule
